// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit types, FSM states and constants
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {IDLE, CORR, COMP, DONE} norm_state_e;

    localparam int BCD_MAX   = 9;
    localparam int BCD_CORR  = 6;
    localparam int BCD_RADIX = 10;

    function automatic logic digit_bad(input bcd_digit_t d);
        return d > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - one-digit cell: borrow correction or ten's-complement step
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic       comp_mode,
    input  bcd_digit_t a,
    input  bcd_digit_t s,
    input  bcd_digit_t r,
    input  logic       b_in,
    output bcd_digit_t d,
    output logic       b_out,
    output logic       bad
);

    logic [4:0] sub_t;
    logic [4:0] t;

    always_comb begin
        sub_t = {1'b0, s} + {4'b0, b_in};
        t     = {1'b0, a} + {4'b0, b_in};
        d     = r;
        b_out = 1'b0;
        bad   = 1'b0;
        if (comp_mode) begin
            // a is the corrected digit d_k; 10 - t wraps mod 16 for out-of-range inputs
            b_out = (t != 5'd0);
            d     = (t == 5'd0) ? 4'd0 : 4'(5'(BCD_RADIX) - t);
        end else begin
            b_out = ({1'b0, a} < sub_t);
            d     = b_out ? (r - 4'(BCD_CORR)) : r;
            bad   = digit_bad(a) | digit_bad(s);
        end
    end

endmodule

// File: rtl/bcd_sub_normalizer.sv
// rtl/bcd_sub_normalizer.sv - serial BCD correction and sign/magnitude conversion of a raw difference
module bcd_sub_normalizer
    import bcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] raw_diff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             invalid
);

    localparam int DIGITS = WIDTH / 4;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    norm_state_e      state;
    logic [WIDTH-1:0] xs, ys, rs, acc;
    logic [IW-1:0]    digit_idx;
    logic             b;

    bcd_digit_t       step_d;
    logic             step_b, step_bad;
    logic             comp_mode;
    logic             last;
    logic [WIDTH-1:0] next_acc;

    assign comp_mode = (state == COMP);
    assign last      = (digit_idx == IW'(DIGITS - 1));
    // Digits are consumed from the bottom nibble and shifted in from the top, LSD first
    assign next_acc  = {step_d, acc[WIDTH-1:4]};

    bcd_digit_step u_step (
        .comp_mode (comp_mode),
        .a         (comp_mode ? acc[3:0] : xs[3:0]),
        .s         (ys[3:0]),
        .r         (rs[3:0]),
        .b_in      (b),
        .d         (step_d),
        .b_out     (step_b),
        .bad       (step_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            invalid   <= 1'b0;
            xs        <= '0;
            ys        <= '0;
            rs        <= '0;
            acc       <= '0;
            digit_idx <= '0;
            b         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs        <= x;
                        ys        <= y;
                        rs        <= raw_diff;
                        acc       <= '0;
                        digit_idx <= '0;
                        b         <= 1'b0;
                        negative  <= 1'b0;
                        invalid   <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= CORR;
                    end
                end
                CORR: begin
                    xs      <= xs >> 4;
                    ys      <= ys >> 4;
                    rs      <= rs >> 4;
                    acc     <= next_acc;
                    invalid <= invalid | step_bad;
                    if (last) begin
                        negative  <= step_b;
                        digit_idx <= '0;
                        b         <= 1'b0;
                        if (step_b) begin
                            state <= COMP;
                        end else begin
                            result    <= next_acc;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        digit_idx <= digit_idx + 1'b1;
                        b         <= step_b;
                    end
                end
                COMP: begin
                    acc <= next_acc;
                    b   <= step_b;
                    if (last) begin
                        digit_idx <= '0;
                        result    <= next_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        digit_idx <= digit_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
